i2c_reg_sequencer: RTL and testbench
====================================

# i2c_reg_sequencer

- Register-access sequencer directly upstream of the byte-level I2C engine in the codec control path.
- Accepts one command per transaction: 7-bit device address, register address and data.
- Expands the command into the engine's byte stream (address byte, register bytes, data bytes; split write/read for reads), drives the engine's go/rnw/wdata handshake and collects read data and slave ACKs.
- Returns one response per command to the codec init/control logic.

## Interface
Parameters:
- C_CLK_DIVISOR, 16'd2: SCL divisor; must equal the engine's divisor. Sizes the post-STOP bus-free wait.
- C_REG_BYTES, 2: register-address bytes (1 or 2), MSB first.
- C_DATA_BYTES, 2: data bytes (1 or 2), MSB first.

Ports:
- clk  in  1  system clock; one clock, everything on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; a command transfers when valid&ready.
- cmd_rnw  in  1  1 = register read, 0 = register write.
- cmd_dev  in  7  7-bit slave address.
- cmd_reg  in  16  register address; low C_REG_BYTES*8 bits used.
- cmd_wdata  in  16  write data; low C_DATA_BYTES*8 bits used.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = NACK seen or command rejected.
- rsp_rdata  out  16  read data, right-aligned, zero-extended; 0 for writes.
- busy  out  1  high from command accept through rsp_valid.
- eng_go, eng_rnw  out  1 each  engine controls.
- eng_wdata  out  8  byte to transmit.
- eng_done  in  1  engine level; high while the engine is in an ACK phase.
- eng_ack  in  1  engine ACK pulse.
- eng_rdata  in  8  engine receive byte.

## Operation
- **Reset:** all outputs 0 except cmd_ready=1; state IDLE.
- **States:** IDLE, XFER, GAP, RESP.
- **IDLE:** on accept, register the command and build the byte list:
  - write: {dev,0}, reg bytes, data bytes.
  - read: phase 1 {dev,0}, reg bytes; phase 2 {dev,1}, then C_DATA_BYTES received bytes.
  - Then set eng_go=1, eng_rnw=0, eng_wdata = first byte, and go to XFER.
- **XFER, byte boundary:** a byte ends on the rising edge of eng_done. In that cycle:
  - A received byte captures eng_rdata into rsp_rdata, MSB byte first.
  - If more bytes remain in the phase, present the next byte on eng_wdata and keep eng_go=1.
  - In read phase 2, after the {dev,1} byte, set eng_rnw=1 for the receive bytes.
  - If this was the last byte of the phase, drop eng_go to 0; the engine issues STOP.
- **ACK check:** for every transmitted byte, eng_ack is sampled in the first cycle after eng_done falls; eng_ack=0 there sets a sticky error flag. Received bytes are not checked.
- **NACK does not abort:** the transaction completes its byte list, and rsp_err reports the error.
- **GAP:** entered after the last byte of a phase. Wait C_CLK_DIVISOR+2 cycles after eng_done falls, so the engine has passed STOP and is idle.
  - Then start read phase 2 (eng_go=1, eng_rnw=0, eng_wdata={dev,1}, back to XFER), or go to RESP.
- **RESP:** one-cycle rsp_valid with rsp_err and rsp_rdata, then IDLE; busy drops with it.
- **Pending command:** held off by cmd_ready=0 while busy; no queueing.
- **Reset mid-transaction:** eng_go drops in the next cycle, the command is discarded and no response is produced. The engine shares rst.

## Timing
- cmd accept at edge N gives eng_go=1 after edge N (registered).
- Next eng_wdata and eng_rnw are valid in the first cycle of eng_done high, before the engine's ACK phase ends.
- eng_go is held stable until the final eng_done rise of the phase.
- rsp_valid asserts C_CLK_DIVISOR+3 cycles after the final eng_done fall.
- eng_go is never raised during GAP.

## Configuration
- **I2C_READ_EN defined:** read commands execute as above.
- **Not defined:**
  - Read logic is compiled out and eng_rnw is tied 0.
  - A read command is accepted, eng_go stays 0, and rsp_valid with rsp_err=1, rsp_rdata=0 follows 2 cycles after accept.

## Test plan
- Write dev=0x0A, reg=0x0002, data=0x0073, slave ACKs all -> wire bytes 0x14,0x00,0x02,0x00,0x73, one STOP, rsp_err=0, rsp_rdata=0.
- Read (I2C_READ_EN) dev=0x0A, reg=0x0000, slave returns 0xA0,0x11 -> 0x14,0x00,0x00, STOP, 0x15, two read bytes, STOP, rsp_rdata=0xA011, rsp_err=0.
- Write with slave NACK on byte 0x02 -> all 5 bytes still clocked, rsp_err=1.
- Read without I2C_READ_EN -> no bus activity, rsp_err=1 two cycles after accept.
- cmd_valid held with two back-to-back writes -> second accepted only after the first rsp_valid; each STOP precedes the next START by at least C_CLK_DIVISOR+2 cycles.
- rst asserted mid-byte during a write -> eng_go=0 next cycle, no rsp_valid; a fresh write afterwards completes with rsp_err=0.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Purpose: turns one register-access command (7-bit device, register address,
// data) into the byte stream for the byte-level I2C engine, drives the engine
// go/rnw/wdata handshake, checks slave ACKs and returns one response.
//
// Build option: I2C_READ_EN. When defined, register reads run as a
// write phase {dev,0}+reg bytes, STOP, then {dev,1}+received bytes, STOP.
// When undefined, the read path is compiled out, eng_rnw is tied 0 and a
// read command is answered with rsp_err=1 two cycles after accept.
//
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while IDLE. rsp_valid is
// a single-cycle pulse with no backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_rnw/dev/reg/wdata    command fields (reg/data MSB byte first)
//   rsp_valid/err/rdata      response pulse, error flag, read data
//   busy                     accept through response
//   eng_go/rnw/wdata         engine controls
//   eng_done/ack/rdata       engine ACK-phase level, ACK pulse, rx byte
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
   parameter logic [15:0] C_CLK_DIVISOR = 16'd2,
   parameter int          C_REG_BYTES   = 2,
   parameter int          C_DATA_BYTES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rnw,
   input  logic [6:0]  cmd_dev,
   input  logic [15:0] cmd_reg,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        eng_go,
   output logic        eng_rnw,
   output logic [7:0]  eng_wdata,
   input  logic        eng_done,
   input  logic        eng_ack,
   input  logic [7:0]  eng_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP, S_RESP} state_t;

   localparam int LIST_W = 8 * (1 + C_REG_BYTES + C_DATA_BYTES);

   state_t       state_q, state_d;
   logic         cmd_ready_q, cmd_ready_d;
   logic         busy_q, busy_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic         rsp_err_q, rsp_err_d;
   logic [15:0]  rsp_rdata_q, rsp_rdata_d;
   logic         eng_go_q, eng_go_d;
   logic         eng_rnw_q, eng_rnw_d;
   logic [7:0]   eng_wdata_q, eng_wdata_d;
   logic         done_q;
   logic         chk_q, chk_d;       // byte in its ACK phase was transmitted
   logic         err_q, err_d;       // sticky NACK / reject flag
   logic         gap_run_q, gap_run_d;
   logic [16:0]  cnt_q, cnt_d;
   logic [39:0]  tx_q, tx_d;         // bytes still to send, MSB-aligned
   logic [2:0]   left_q, left_d;     // bytes left in the current phase
   logic [15:0]  rdata_q, rdata_d;
`ifdef I2C_READ_EN
   logic         rd_q, rd_d;
   logic         ph2_q, ph2_d;
   logic [6:0]   dev_q, dev_d;
`endif

   logic [LIST_W-1:0] list_w;
   logic [39:0]       tx_init;
   logic              done_rise, done_fall;
   logic              reject, start_ph2;

   // Full write byte list; a read phase 1 simply stops before the data bytes.
   always_comb begin
      list_w  = {cmd_dev, 1'b0, cmd_reg[8*C_REG_BYTES-1:0], cmd_wdata[8*C_DATA_BYTES-1:0]};
      tx_init = 40'(list_w) << (40 - LIST_W);
   end

   always_comb begin
      done_rise = eng_done & ~done_q;
      done_fall = ~eng_done & done_q;
`ifdef I2C_READ_EN
      reject    = 1'b0;
      start_ph2 = rd_q & ~ph2_q;
`else
      reject    = cmd_rnw;
      start_ph2 = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 16'h0000;
      eng_go_d    = eng_go_q;
      eng_rnw_d   = eng_rnw_q;
      eng_wdata_d = eng_wdata_q;
      chk_d       = chk_q;
      err_d       = err_q;
      gap_run_d   = gap_run_q;
      cnt_d       = cnt_q;
      tx_d        = tx_q;
      left_d      = left_q;
      rdata_d     = rdata_q;
`ifdef I2C_READ_EN
      rd_d        = rd_q;
      ph2_d       = ph2_q;
      dev_d       = dev_q;
`endif

      // ACK of a transmitted byte is judged in the first cycle eng_done is low.
      if (state_q != S_IDLE && done_fall && chk_q && !eng_ack) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               err_d       = 1'b0;
               rdata_d     = 16'h0000;
               chk_d       = 1'b0;
               gap_run_d   = 1'b0;
`ifdef I2C_READ_EN
               rd_d        = cmd_rnw;
               ph2_d       = 1'b0;
               dev_d       = cmd_dev;
`endif
               if (reject) begin
                  // Reuse the GAP countdown to answer two cycles later.
                  state_d   = S_GAP;
                  gap_run_d = 1'b1;
                  cnt_d     = 17'd1;
                  err_d     = 1'b1;
               end else begin
                  state_d     = S_XFER;
                  eng_go_d    = 1'b1;
                  eng_rnw_d   = 1'b0;
                  eng_wdata_d = tx_init[39:32];
                  tx_d        = tx_init << 8;
                  left_d      = cmd_rnw ? 3'(C_REG_BYTES) : 3'(C_REG_BYTES + C_DATA_BYTES);
               end
            end
         end

         S_XFER: begin
            if (done_rise) begin
               chk_d = ~eng_rnw_q;
               if (eng_rnw_q) begin
                  rdata_d = {rdata_q[7:0], eng_rdata};
               end
               if (left_q != 3'd0) begin
                  left_d      = left_q - 3'd1;
                  eng_wdata_d = tx_q[39:32];
                  tx_d        = tx_q << 8;
`ifdef I2C_READ_EN
                  // Everything after {dev,1} in phase 2 is received.
                  if (ph2_q) begin
                     eng_rnw_d   = 1'b1;
                     eng_wdata_d = 8'h00;
                  end
`endif
               end else begin
                  // Last byte of the phase: engine sees go low and issues STOP.
                  eng_go_d  = 1'b0;
                  state_d   = S_GAP;
                  gap_run_d = 1'b0;
               end
            end
         end

         S_GAP: begin
            if (!gap_run_q) begin
               if (done_fall) begin
                  gap_run_d = 1'b1;
                  cnt_d     = 17'(C_CLK_DIVISOR) + 17'd1;
               end
            end else if (cnt_q != 17'd0) begin
               cnt_d = cnt_q - 17'd1;
            end else if (start_ph2) begin
`ifdef I2C_READ_EN
               ph2_d       = 1'b1;
               state_d     = S_XFER;
               eng_go_d    = 1'b1;
               eng_rnw_d   = 1'b0;
               eng_wdata_d = {dev_q, 1'b1};
               left_d      = 3'(C_DATA_BYTES);
`endif
            end else begin
               state_d     = S_RESP;
               eng_rnw_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_rdata_d = rdata_q;
            end
         end

         S_RESP: begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            cmd_ready_d = 1'b1;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         eng_go_q    <= 1'b0;
         eng_rnw_q   <= 1'b0;
         eng_wdata_q <= 8'h00;
         done_q      <= 1'b0;
         chk_q       <= 1'b0;
         err_q       <= 1'b0;
         gap_run_q   <= 1'b0;
         cnt_q       <= 17'd0;
         tx_q        <= 40'd0;
         left_q      <= 3'd0;
         rdata_q     <= 16'h0000;
`ifdef I2C_READ_EN
         rd_q        <= 1'b0;
         ph2_q       <= 1'b0;
         dev_q       <= 7'd0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         eng_go_q    <= eng_go_d;
         eng_rnw_q   <= eng_rnw_d;
         eng_wdata_q <= eng_wdata_d;
         done_q      <= eng_done;
         chk_q       <= chk_d;
         err_q       <= err_d;
         gap_run_q   <= gap_run_d;
         cnt_q       <= cnt_d;
         tx_q        <= tx_d;
         left_q      <= left_d;
         rdata_q     <= rdata_d;
`ifdef I2C_READ_EN
         rd_q        <= rd_d;
         ph2_q       <= ph2_d;
         dev_q       <= dev_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign eng_go    = eng_go_q;
   assign eng_wdata = eng_wdata_q;
`ifdef I2C_READ_EN
   assign eng_rnw   = eng_rnw_q;
`else
   assign eng_rnw   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//
// Directed bench for i2c_reg_sequencer with a behavioural byte engine.
// Engine model: on eng_go it starts a byte, shifts for 8 cycles, holds
// eng_done for 3 cycles (ACK phase), then drops eng_done together with a
// one-cycle eng_ack for transmitted bytes. At the end of the ACK phase it
// continues if eng_go is still high, otherwise it logs a STOP.
// Wire log entries: 10'h0xx transmitted byte, 10'h1xx received byte,
// 10'h300 STOP.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

   localparam logic [15:0] DIV = 16'd2;

   logic        clk;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [6:0]  cmd_dev;
   logic [15:0] cmd_reg, cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic        busy, eng_go, eng_rnw;
   logic [7:0]  eng_wdata;
   logic        eng_done, eng_ack;
   logic [7:0]  eng_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [9:0] obs_q[$];
   logic [7:0] rx_q[$];
   logic [8:0] nack_on  = 9'h100;   // bit 8 set = slave ACKs everything
   int         stop_cyc = -100000;
   int         last_gap = 0;
   int         starts   = 0;

   i2c_reg_sequencer #(
      .C_CLK_DIVISOR(DIV),
      .C_REG_BYTES  (2),
      .C_DATA_BYTES (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_rnw  (cmd_rnw),
      .cmd_dev  (cmd_dev),
      .cmd_reg  (cmd_reg),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_err  (rsp_err),
      .rsp_rdata(rsp_rdata),
      .busy     (busy),
      .eng_go   (eng_go),
      .eng_rnw  (eng_rnw),
      .eng_wdata(eng_wdata),
      .eng_done (eng_done),
      .eng_ack  (eng_ack),
      .eng_rdata(eng_rdata)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: cycles=%0d required=<50000", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- engine model ----------------
   initial begin
      int         st;
      int         cnt;
      logic [7:0] b;
      logic       r;
      st = 0; cnt = 0; b = 8'h00; r = 1'b0;
      eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         eng_ack = 1'b0;
         if (rst) begin
            st = 0; cnt = 0; eng_done = 1'b0;
         end else begin
            case (st)
               0: if (eng_go) begin
                  last_gap = cyc - stop_cyc;
                  starts++;
                  b = eng_wdata; r = eng_rnw; cnt = 0; st = 1;
               end
               1: begin
                  cnt++;
                  if (cnt == 6) begin
                     if (r) begin
                        eng_rdata = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
                        obs_q.push_back({2'b01, eng_rdata});
                     end else begin
                        obs_q.push_back({2'b00, b});
                     end
                  end
                  if (cnt == 8) begin
                     eng_done = 1'b1; cnt = 0; st = 2;
                  end
               end
               2: begin
                  cnt++;
                  if (cnt == 3) begin
                     eng_done = 1'b0;
                     if (!r) eng_ack = !(nack_on[8] == 1'b0 && b == nack_on[7:0]);
                     if (eng_go) begin
                        b = eng_wdata; r = eng_rnw; cnt = 0; st = 1;
                     end else begin
                        obs_q.push_back(10'h300);
                        stop_cyc = cyc;
                        st = 0;
                     end
                  end
               end
               default: st = 0;
            endcase
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic rnw, input logic [6:0] dev, input logic [15:0] rg,
                           input logic [15:0] wd, output logic ok, output int at);
      cmd_rnw = rnw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
      cmd_valid = 1'b1;
      ok = 1'b0; at = -1;
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready) begin
            @(posedge clk); #1;
            ok = 1'b1; at = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int max_cyc, output logic got, output int at);
      got = 1'b0; at = -1;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            got = 1'b1; at = cyc;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_dev = 7'h00; cmd_reg = 16'h0000; cmd_wdata = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got=%b want=1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got=%b want=0", rsp_valid); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got=%b want=0", rsp_err); end
      total++; if (rsp_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rsp_rdata: got=%h want=0000", rsp_rdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
      total++; if (eng_go !== 1'b0) begin bad++; $display("FAIL reset_eng_go: got=%b want=0", eng_go); end
      total++; if (eng_rnw !== 1'b0) begin bad++; $display("FAIL reset_eng_rnw: got=%b want=0", eng_rnw); end
      total++; if (eng_wdata !== 8'h00) begin bad++; $display("FAIL reset_eng_wdata: got=%h want=00", eng_wdata); end
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_write();
      logic ok, got;
      int acc, at;
      logic [9:0] exp_q[$];
      logic [9:0] v;
      obs_q.delete(); nack_on = 9'h100;
      exp_q = '{10'h014, 10'h000, 10'h002, 10'h000, 10'h073, 10'h300};
      send_cmd(1'b0, 7'h0A, 16'h0002, 16'h0073, ok, acc);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL write_accept: got=%b want=1", ok); end
      total++; if (eng_go !== 1'b1 || eng_wdata !== 8'h14 || eng_rnw !== 1'b0) begin
         bad++; $display("FAIL write_first_byte: go=%b wdata=%h rnw=%b want go=1 wdata=14 rnw=0", eng_go, eng_wdata, eng_rnw);
      end
      total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
         bad++; $display("FAIL write_busy: busy=%b ready=%b want busy=1 ready=0", busy, cmd_ready);
      end
      wait_rsp(300, got, at);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL write_rsp_timeout: got=%b want=1", got); end
      if (got) begin
         total++; if (rsp_err !== 1'b0 || rsp_rdata !== 16'h0000) begin
            bad++; $display("FAIL write_rsp: err=%b rdata=%h want err=0 rdata=0000", rsp_err, rsp_rdata);
         end
         total++; if (at - stop_cyc != int'(DIV) + 3) begin
            bad++; $display("FAIL write_rsp_latency: got=%0d want=%0d", at - stop_cyc, int'(DIV) + 3);
         end
         total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL write_busy_at_rsp: busy=%b ready=%b want busy=1 ready=0", busy, cmd_ready);
         end
         @(posedge clk); #1;
         total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL write_after_rsp: valid=%b busy=%b ready=%b want 0 0 1", rsp_valid, busy, cmd_ready);
         end
      end
      total++; if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL write_log_len: got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         v = (i < obs_q.size()) ? obs_q[i] : 10'h3FF;
         total++; if (v !== exp_q[i]) begin bad++; $display("FAIL write_log[%0d]: got=%h want=%h", i, v, exp_q[i]); end
      end
   endtask

   task automatic test_nack();
      logic ok, got;
      int acc, at;
      logic [9:0] exp_q[$];
      logic [9:0] v;
      obs_q.delete(); nack_on = 9'h002;
      exp_q = '{10'h014, 10'h000, 10'h002, 10'h000, 10'h073, 10'h300};
      send_cmd(1'b0, 7'h0A, 16'h0002, 16'h0073, ok, acc);
      wait_rsp(300, got, at);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL nack_rsp_timeout: got=%b want=1", got); end
      if (got) begin
         total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL nack_rsp_err: got=%b want=1", rsp_err); end
      end
      total++; if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL nack_log_len: got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         v = (i < obs_q.size()) ? obs_q[i] : 10'h3FF;
         total++; if (v !== exp_q[i]) begin bad++; $display("FAIL nack_log[%0d]: got=%h want=%h", i, v, exp_q[i]); end
      end
      nack_on = 9'h100;
      repeat (2) begin @(posedge clk); #1; end
   endtask

`ifdef I2C_READ_EN
   task automatic test_read();
      logic ok, got;
      int acc, at;
      logic [9:0] exp_q[$];
      logic [9:0] v;
      obs_q.delete(); nack_on = 9'h100;
      rx_q = '{8'hA0, 8'h11};
      exp_q = '{10'h014, 10'h000, 10'h000, 10'h300, 10'h015, 10'h1A0, 10'h111, 10'h300};
      send_cmd(1'b1, 7'h0A, 16'h0000, 16'h0000, ok, acc);
      wait_rsp(400, got, at);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL read_rsp_timeout: got=%b want=1", got); end
      if (got) begin
         total++; if (rsp_err !== 1'b0 || rsp_rdata !== 16'hA011) begin
            bad++; $display("FAIL read_rsp: err=%b rdata=%h want err=0 rdata=a011", rsp_err, rsp_rdata);
         end
         total++; if (at - stop_cyc != int'(DIV) + 3) begin
            bad++; $display("FAIL read_rsp_latency: got=%0d want=%0d", at - stop_cyc, int'(DIV) + 3);
         end
      end
      total++; if (last_gap < int'(DIV) + 2) begin
         bad++; $display("FAIL read_bus_free: got=%0d want>=%0d", last_gap, int'(DIV) + 2);
      end
      total++; if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL read_log_len: got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         v = (i < obs_q.size()) ? obs_q[i] : 10'h3FF;
         total++; if (v !== exp_q[i]) begin bad++; $display("FAIL read_log[%0d]: got=%h want=%h", i, v, exp_q[i]); end
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask
`else
   task automatic test_read_reject();
      logic ok;
      int acc, s0;
      obs_q.delete();
      s0 = starts;
      send_cmd(1'b1, 7'h0A, 16'h0000, 16'h0000, ok, acc);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL reject_accept: got=%b want=1", ok); end
      total++; if (eng_go !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL reject_accept_cycle: go=%b busy=%b want go=0 busy=1", eng_go, busy);
      end
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b0 || eng_go !== 1'b0) begin
         bad++; $display("FAIL reject_cycle1: valid=%b go=%b want 0 0", rsp_valid, eng_go);
      end
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0000) begin
         bad++; $display("FAIL reject_rsp: valid=%b err=%b rdata=%h want 1 1 0000", rsp_valid, rsp_err, rsp_rdata);
      end
      total++; if (eng_rnw !== 1'b0) begin bad++; $display("FAIL reject_eng_rnw: got=%b want=0", eng_rnw); end
      repeat (10) begin @(posedge clk); #1; end
      total++; if (starts != s0 || obs_q.size() != 0) begin
         bad++; $display("FAIL reject_bus_quiet: starts=%0d log=%0d want starts=%0d log=0", starts, obs_q.size(), s0);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic pre, got1, got2, e1;
      int acc1, acc2, r1, r2;
      logic [9:0] exp_q[$];
      logic [9:0] v;
      obs_q.delete(); nack_on = 9'h100;
      exp_q = '{10'h042, 10'h012, 10'h034, 10'h0BE, 10'h0EF, 10'h300,
                10'h0A0, 10'h000, 10'h0FF, 10'h000, 10'h001, 10'h300};
      cmd_rnw = 1'b0; cmd_dev = 7'h21; cmd_reg = 16'h1234; cmd_wdata = 16'hBEEF;
      cmd_valid = 1'b1;
      acc1 = -1;
      for (int i = 0; i < 20 && acc1 < 0; i++) begin
         pre = cmd_ready; @(posedge clk); #1;
         if (pre) acc1 = cyc;
      end
      cmd_dev = 7'h50; cmd_reg = 16'h00FF; cmd_wdata = 16'h0001;
      got1 = 1'b0; r1 = -1; acc2 = -1; e1 = 1'bx;
      for (int i = 0; i < 400 && acc2 < 0; i++) begin
         pre = cmd_ready; @(posedge clk); #1;
         if (rsp_valid && !got1) begin got1 = 1'b1; r1 = cyc; e1 = rsp_err; end
         if (pre) acc2 = cyc;
      end
      cmd_valid = 1'b0;
      total++; if (acc1 < 0) begin bad++; $display("FAIL b2b_first_accept: got=%0d want>=0", acc1); end
      total++; if (got1 !== 1'b1 || e1 !== 1'b0) begin bad++; $display("FAIL b2b_first_rsp: got=%b err=%b want 1 0", got1, e1); end
      total++; if (acc2 <= r1 || acc2 < 0) begin bad++; $display("FAIL b2b_second_accept: acc=%0d rsp=%0d want acc>rsp", acc2, r1); end
      wait_rsp(300, got2, r2);
      total++; if (got2 !== 1'b1) begin bad++; $display("FAIL b2b_second_rsp_timeout: got=%b want=1", got2); end
      if (got2) begin
         total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL b2b_second_err: got=%b want=0", rsp_err); end
      end
      total++; if (last_gap < int'(DIV) + 2) begin
         bad++; $display("FAIL b2b_bus_free: got=%0d want>=%0d", last_gap, int'(DIV) + 2);
      end
      total++; if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL b2b_log_len: got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         v = (i < obs_q.size()) ? obs_q[i] : 10'h3FF;
         total++; if (v !== exp_q[i]) begin bad++; $display("FAIL b2b_log[%0d]: got=%h want=%h", i, v, exp_q[i]); end
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset_mid();
      logic ok, got, seen;
      int acc, at;
      logic [9:0] exp_q[$];
      logic [9:0] v;
      obs_q.delete(); nack_on = 9'h100;
      send_cmd(1'b0, 7'h0A, 16'h0002, 16'h0073, ok, acc);
      repeat (14) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (eng_go !== 1'b0) begin bad++; $display("FAIL rstmid_eng_go: got=%b want=0", eng_go); end
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL rstmid_state: ready=%b busy=%b want 1 0", cmd_ready, busy);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp: got=%b want=0", seen); end
      obs_q.delete();
      exp_q = '{10'h066, 10'h000, 10'h010, 10'h05A, 10'h05A, 10'h300};
      send_cmd(1'b0, 7'h33, 16'h0010, 16'h5A5A, ok, acc);
      wait_rsp(300, got, at);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_timeout: got=%b want=1", got); end
      if (got) begin
         total++; if (rsp_err !== 1'b0 || rsp_rdata !== 16'h0000) begin
            bad++; $display("FAIL rstmid_fresh_rsp: err=%b rdata=%h want 0 0000", rsp_err, rsp_rdata);
         end
      end
      total++; if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rstmid_log_len: got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         v = (i < obs_q.size()) ? obs_q[i] : 10'h3FF;
         total++; if (v !== exp_q[i]) begin bad++; $display("FAIL rstmid_log[%0d]: got=%h want=%h", i, v, exp_q[i]); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write();
      test_nack();
`ifdef I2C_READ_EN
      test_read();
`else
      test_read_reject();
`endif
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
